// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------
// | uart_pkg : shared types and constants for the UART receive path
// | Rev 1.0  : initial release (UART_RX_PARITY_EN selects the 11-bit frame)
// +----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------
// | uart_baud_tick : divides clk by CLK_DIV into a one-cycle tick, with restart
// | Rev 1.0        : initial release
// +----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [15:0] c_last = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        o_tick = 1'b0;
        if (i_restart) begin
            cnt_d = 16'd0;
        end else if (cnt_q == c_last) begin
            cnt_d  = 16'd0;
            o_tick = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------
// | uart_rx : 16x oversampling UART receiver with valid/ready holding register
// | Rev 1.0 : initial release; define UART_RX_PARITY_EN for the parity variant
// +----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 4,
`ifdef UART_RX_PARITY_EN
    parameter int PARITY_ODD = 0,
`endif
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int                c_sc_w   = $clog2(OVERSAMPLE);
    localparam logic [c_sc_w-1:0] c_sc_one = c_sc_w'(1);
    localparam logic [c_sc_w-1:0] c_vote_a = c_sc_w'(MID_SAMPLE - 1);
    localparam logic [c_sc_w-1:0] c_vote_b = c_sc_w'(MID_SAMPLE);
    localparam logic [c_sc_w-1:0] c_vote_c = c_sc_w'(MID_SAMPLE + 1);
    localparam logic [2:0]        c_last_b = 3'(DATA_BITS - 1);

    // Reset asserts asynchronously but releases on a clock edge.
    logic rst_meta_q;
    logic rst_sync_q;
    logic rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end
    assign rst_int_n = rst_sync_q;

    logic              sync_meta_q, rx_s_q, rx_prev_q;
    state_e            state_q, state_d;
    logic [c_sc_w-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [1:0]        vote_q, vote_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              framing_err_q, framing_err_d;
    logic              overrun_err_q, overrun_err_d;
    logic              tick, vote_pt, vote_bit, stop_ok;
`ifdef UART_RX_PARITY_EN
    localparam logic c_par_odd = (PARITY_ODD != 0);
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
`endif

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .i_restart (state_q == IDLE),
        .o_tick    (tick)
    );

    assign vote_pt  = tick && (samp_cnt_q == c_vote_c);
    assign vote_bit = maj3(vote_q[1], vote_q[0], rx_s_q);

    always_comb begin
        state_d       = state_q;
        samp_cnt_d    = samp_cnt_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        vote_d        = vote_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        framing_err_d = 1'b0;
        overrun_err_d = 1'b0;
        stop_ok       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d     = par_bad_q;
        parity_err_d  = 1'b0;
`endif

        if (tick) begin
            samp_cnt_d = samp_cnt_q + c_sc_one;
            if (samp_cnt_q == c_vote_a) vote_d[1] = rx_s_q;
            if (samp_cnt_q == c_vote_b) vote_d[0] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                samp_cnt_d = '0;
                if (rx_prev_q && !rx_s_q) state_d = START;
            end
            START: begin
                if (vote_pt) begin
                    if (!vote_bit) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (vote_pt) begin
                    shreg_d[bit_idx_q] = vote_bit;
                    if (bit_idx_q == c_last_b) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (vote_pt) begin
                    par_bad_d = ((^shreg_q) ^ vote_bit) != c_par_odd;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Frame ends at the stop vote so a short stop bit still works.
                if (vote_pt) begin
                    if (vote_bit) begin
                        stop_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        // A completing byte loads only if the slot is empty or being drained now.
        if (stop_ok) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = par_bad_q;
`endif
            end else begin
                overrun_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync_meta_q   <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            state_q       <= IDLE;
            samp_cnt_q    <= '0;
            bit_idx_q     <= 3'd0;
            shreg_q       <= 8'd0;
            vote_q        <= 2'd0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sync_meta_q   <= rx_in;
            rx_s_q        <= sync_meta_q;
            rx_prev_q     <= rx_s_q;
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            vote_q        <= vote_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_uart_rx : directed self-checking bench for uart_rx with a byte scoreboard
// | Rev 1.0    : initial release
// +----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_DIV = 4;
    localparam int BIT     = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 10 + PB;
    // Cycle (after the start edge) in which the stop vote completes the byte.
    localparam int DONE_CYC = 2 + (154 + 16 * PB) * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, framing_err, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rises = 0, fe_cnt = 0, oe_cnt = 0, pe_cnt = 0, last_rise = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && !prev_v) begin
            rises++;
            last_rise = cyc;
        end
        prev_v = rx_valid;
        if (framing_err) fe_cnt++;
        if (overrun_err) oe_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
    end

    int         checks = 0;
    int         failures = 0;
    int         t_start = 0;
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serialise one frame starting now (caller sits on a negedge).
    task automatic drive_frame(input logic [7:0] d, input logic stop_v, input logic flip,
                               input int max_cyc);
        logic [10:0] bits;
        int total;
        total = 0;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (PB == 1) bits[9] = (^d) ^ flip;
        bits[NBITS-1] = stop_v;
        t_start = cyc;
        for (int b = 0; b < NBITS; b++) begin
            for (int k = 0; k < BIT; k++) begin
                if (total >= max_cyc) return;
                rx_in = bits[b];
                @(negedge clk);
                total++;
            end
        end
    endtask

    task automatic expect_byte(input string tag);
        int n;
        n = 0;
        while (!rx_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb: observed=%0h expected=<scoreboard empty>", tag, rx_data);
        end else begin
            chk({tag, "_data"}, 32'(rx_data), 32'(sb.pop_front()));
        end
    endtask

    task automatic accept(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk({tag, "_clear"}, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, fe0, oe0, pe0, r0;

        // Reset values
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_ferr", 32'(framing_err), 32'd0);
        chk("rst_oerr", 32'(overrun_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Single frame 0xA5 and its latency
        sb.push_back(8'hA5);
        drive_frame(8'hA5, 1'b1, 1'b0, 1 << 30);
        expect_byte("a5");
        lat = last_rise - t_start;
        chk($sformatf("a5_latency(%0d)", lat),
            32'((lat >= DONE_CYC + 1 - CLK_DIV) && (lat <= DONE_CYC + 1 + CLK_DIV)), 32'd1);
        chk("a5_ferr", 32'(fe_cnt), 32'd0);
        chk("a5_perr", 32'(pe_cnt), 32'd0);
        accept("a5");

        // 20-clk glitch must not start a frame
        r0 = rises; fe0 = fe_cnt; oe0 = oe_cnt;
        rx_in = 1'b0;
        repeat (20) @(negedge clk);
        rx_in = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_rises", 32'(rises), 32'(r0));
        chk("glitch_errs", 32'(fe_cnt + oe_cnt), 32'(fe0 + oe0));

        // Bad stop bit then line held low
        r0 = rises; fe0 = fe_cnt;
        drive_frame(8'h3C, 1'b0, 1'b0, 1 << 30);
        repeat (500) @(negedge clk);
        chk("break_busy_held", 32'(busy), 32'd1);
        chk("break_ferr_once", 32'(fe_cnt), 32'(fe0 + 1));
        rx_in = 1'b1;
        repeat (300) @(negedge clk);
        chk("break_busy_release", 32'(busy), 32'd0);
        chk("break_no_frame", 32'(rises), 32'(r0));
        chk("break_ferr_total", 32'(fe_cnt), 32'(fe0 + 1));

        // Overrun: two frames back-to-back with no consumer
        oe0 = oe_cnt;
        sb.push_back(8'h11);
        drive_frame(8'h11, 1'b1, 1'b0, 1 << 30);
        drive_frame(8'h22, 1'b1, 1'b0, 1 << 30);
        expect_byte("ovr");
        chk("ovr_pulse", 32'(oe_cnt), 32'(oe0 + 1));
        accept("ovr");

        // Accept in the exact completion cycle of the next byte
        oe0 = oe_cnt;
        sb.push_back(8'h55);
        drive_frame(8'h55, 1'b1, 1'b0, 1 << 30);
        expect_byte("b55");
        sb.push_back(8'h66);
        fork
            drive_frame(8'h66, 1'b1, 1'b0, 1 << 30);
            begin
                repeat (DONE_CYC) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        expect_byte("b66");
        chk("same_cycle_no_ovr", 32'(oe_cnt), 32'(oe0));
        accept("b66");

        // Reset in the middle of data bit 4
        drive_frame(8'h0F, 1'b1, 1'b0, 5 * BIT + BIT / 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rx_valid), 32'd0);
        chk("mid_rst_data", 32'(rx_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ferr", 32'(framing_err), 32'd0);
        chk("mid_rst_oerr", 32'(overrun_err), 32'd0);
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        sb.push_back(8'h0F);
        drive_frame(8'h0F, 1'b1, 1'b0, 1 << 30);
        expect_byte("b0f");
        accept("b0f");

`ifdef UART_RX_PARITY_EN
        pe0 = pe_cnt;
        sb.push_back(8'h0F);
        drive_frame(8'h0F, 1'b1, 1'b1, 1 << 30);
        expect_byte("par");
        chk("par_pulse", 32'(pe_cnt), 32'(pe0 + 1));
        accept("par");
`else
        pe0 = pe_cnt;
        chk("no_parity_pulses", 32'(pe0), 32'd0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive end of the team's UART link, the counterpart to the transmit path that serialises a 10-bit frame: start bit, data[0]..data[7] LSB first, stop bit.
- Oversamples the asynchronous serial line at 16x the bit rate, validates the start bit, majority-votes every bit at mid-cell and checks the stop bit.
- Delivers each byte through a single-entry valid/ready holding register to the host-side logic.

Parameters:
- CLK_DIV, 4, clk cycles per oversample tick; bit period = 16*CLK_DIV clk cycles; legal range 1..65535.
- OVERSAMPLE, 16, samples per bit; fixed value, exposed only for readability.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_in  input  1  serial line, asynchronous to clk; idles high
- rx_data  output  8  received byte, stable while rx_valid=1
- rx_valid  output  1  byte available in the holding register
- rx_ready  input  1  consumer accepts the byte when rx_valid&&rx_ready
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  one-cycle pulse: byte dropped because the holding register was full
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async assert, sync deassert inside the block): rx_data=0, rx_valid=0, framing_err=0, overrun_err=0, busy=0, FSM=IDLE, both synchroniser flops=1, all counters=0.
- Synchroniser: rx_in passes through 2 flops, giving rx_s. All decisions use rx_s only, never the raw rx_in.
- Tick generator: a counter wraps at CLK_DIV-1 and emits a 1-cycle tick. In IDLE it is held at 0 and restarts on the start edge, so samples stay phase-aligned to that edge.
- Sample counter: 0..15, advances on each tick. Majority vote of rx_s at sample counts 7, 8 and 9 (2-of-3) gives the bit value; the vote resolves on the tick that ends count 9.
- FSM states:
  - IDLE: a falling edge on rx_s (previous 1, current 0) -> START.
  - START: at the vote point, bit=0 -> DATA with bit_idx=0. Bit=1 is a glitch -> IDLE with no flags.
  - DATA: at each vote point, shift the bit into shreg[bit_idx]. bit_idx 0..7; after bit 7 -> STOP.
  - STOP: bit=1 -> deliver the byte, then IDLE. Bit=0 -> pulse framing_err, discard the byte, then BREAK.
  - BREAK: wait for rx_s=1 (line returned to idle), then IDLE. This guarantees a held-low line produces no spurious frames.
- Frame end: the FSM returns to IDLE at the stop-bit vote point, not at the end of the stop cell. This allows back-to-back frames with a stop bit as short as 10/16 of a bit.
- Delivery: one clk after the stop vote, rx_data=shreg and rx_valid=1. rx_valid stays high until a cycle with rx_ready=1, and clears on the following edge.
- Overrun: a byte completes while rx_valid=1 and rx_ready=0 -> pulse overrun_err; keep the old rx_data; drop the new byte.
- Same-cycle accept: rx_ready=1 in the same cycle a new byte completes -> accept the old byte, load the new one, leave rx_valid=1, no overrun.
- Latency: falling edge on rx_in to rx_valid is 2 (sync) + 9.625*16*CLK_DIV + 1 clk, within ±1 tick of edge quantisation.
- rx_in toggling mid-frame never aborts the frame; only the vote values matter.
- Reset mid-frame: everything returns to reset values immediately, and the partial byte is lost.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds state PARITY between DATA and STOP.
  - Adds parameter PARITY_ODD (default 0 = even parity).
  - Adds output parity_err (1 bit; one-cycle pulse, reset 0).
  - A parity mismatch pulses parity_err in the same cycle the byte is delivered. The byte is still delivered.
  - Frame becomes 11 bits.
- When undefined: no PARITY state, no parity_err port, 10-bit frame exactly as above.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - OVERSAMPLE=16
  - MID_SAMPLE=8
  - DATA_BITS=8
  - FRAME_BITS=10
- Sub-module uart_baud_tick: CLK_DIV counter with a sync restart input. The future TX datapath reuses it at 16x.

Test Plan (CLK_DIV=4, so 64 clk per bit):
- Send 0xA5 with 1 stop bit -> rx_data=0xA5, rx_valid rises ~619 clk after the start edge, framing_err=0.
- Send a 20-clk low glitch on an idle line -> FSM returns to IDLE, no rx_valid, no error pulses.
- Send 0x3C with the stop bit driven low, then hold the line low 500 clk, then release -> one framing_err pulse, no rx_valid, busy stays high until the release, no further frames.
- Send 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_valid=1 with rx_data=0x11, overrun_err pulses once. Then raise rx_ready -> rx_valid clears.
- Send 0x55, and assert rx_ready exactly in the completion cycle of a following 0x66 -> no overrun, rx_data=0x66 with rx_valid=1.
- Assert rst_n=0 mid-way through data bit 4, release, then send 0x0F -> all outputs 0 during reset, next byte received as 0x0F. With UART_RX_PARITY_EN, a flipped parity bit on 0x0F -> parity_err pulse and rx_data=0x0F.
